// File: rtl/mack_dtack_gen_if.sv
// CPU-side bus signals for the DTACK/BERR generator. The slave modport is the generator.
// All signals are active-low.
interface mack_dtack_gen_if;
  logic AS;
  logic ROMEN;
  logic RAMEN;
  logic DUARTEN;
  logic EXT_DTACK;
  logic DTACK_OUT;
  logic BERR;

  modport master (
    output AS, ROMEN, RAMEN, DUARTEN, EXT_DTACK,
    input  DTACK_OUT, BERR
  );

  modport slave (
    input  AS, ROMEN, RAMEN, DUARTEN, EXT_DTACK,
    output DTACK_OUT, BERR
  );
endinterface

// File: rtl/mack_dtack_gen.sv
// Wait-state DTACK generator for ROM/RAM/DUART, with an optional bus-error timeout.
// The timeout and FAULT state exist only when MACK_BERR_TIMEOUT_EN is defined.
module mack_dtack_gen #(
  parameter int unsigned ROM_WAIT   = 2,
  parameter int unsigned RAM_WAIT   = 0,
  parameter int unsigned DUART_WAIT = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              CLK,
  input  logic              RST,
  mack_dtack_gen_if.slave   bus
);

  localparam logic [3:0] ROM_W   = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W   = 4'(RAM_WAIT);
  localparam logic [3:0] DUART_W = 4'(DUART_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2
`ifdef MACK_BERR_TIMEOUT_EN
    , FAULT = 2'd3
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wcnt;
  logic       r_armed;
  logic       r_dtack;
  logic       w_dtack_n;
  logic       w_sel_valid;
  logic [3:0] w_sel_wait;
  logic       w_start;
  logic       w_timeout;

  assign w_sel_valid = ~bus.DUARTEN | ~bus.ROMEN | ~bus.RAMEN;
  assign w_sel_wait  = ~bus.DUARTEN ? DUART_W :
                       ~bus.ROMEN   ? ROM_W   : RAM_W;
  // r_armed records AS seen high while idle, so a cycle still in progress
  // after reset or an ACK is never picked up halfway through.
  assign w_start     = (r_state == IDLE) & ~bus.AS & w_sel_valid & r_armed;

`ifdef MACK_BERR_TIMEOUT_EN
  logic [7:0] r_to;
  logic       r_berr;

  assign w_timeout = ((r_state == IDLE) | (r_state == WAIT)) & ~bus.AS &
                     (r_to == 8'(TIMEOUT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_to <= '0;
    end else if (bus.AS | ~bus.EXT_DTACK) begin
      r_to <= '0;
    end else if (r_dtack && r_to != '1) begin
      r_to <= r_to + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_berr <= 1'b1;
    else     r_berr <= (w_next != FAULT);
  end

  assign bus.BERR = r_berr;
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign w_unused_cfg = (TIMEOUT > 0) ^ bus.EXT_DTACK;
  assign bus.BERR     = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_next = (w_sel_wait != '0) ? WAIT : ACK;
      WAIT:    if (bus.AS) w_next = IDLE;
               else if (r_wcnt == 4'd1) w_next = ACK;
      ACK:     if (bus.AS) w_next = IDLE;
`ifdef MACK_BERR_TIMEOUT_EN
      FAULT:   if (bus.AS) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_timeout) w_next = FAULT;
`else
      default: w_next = IDLE;
    endcase
`endif
  end

  // DTACK is released on the same edge that sees AS high, so it follows
  // the current state qualified by AS rather than the next state.
  always_comb begin
    w_dtack_n = ~((r_state == ACK) & ~bus.AS);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wcnt  <= '0;
      r_armed <= 1'b0;
      r_dtack <= 1'b1;
    end else begin
      r_dtack <= w_dtack_n;
      if (w_start)
        r_wcnt <= w_sel_wait;
      else if (r_state == WAIT && r_wcnt != '0)
        r_wcnt <= r_wcnt - 4'd1;
      if (w_start)
        r_armed <= 1'b0;
      else if (r_state == IDLE && bus.AS)
        r_armed <= 1'b1;
      else if (r_state != IDLE)
        r_armed <= 1'b0;
    end
  end

  assign bus.DTACK_OUT = r_dtack;

endmodule

// File: tb/tb_mack_dtack_gen.sv
// Directed bench for mack_dtack_gen with default wait counts (ROM 2, RAM 0, DUART 3, TIMEOUT 64).
module tb_mack_dtack_gen;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  mack_dtack_gen_if bus ();

  mack_dtack_gen #(
    .ROM_WAIT   (2),
    .RAM_WAIT   (0),
    .DUART_WAIT (3),
    .TIMEOUT    (64)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic as, input logic rom, input logic ram,
                       input logic duart, input logic ext);
    bus.AS        = as;
    bus.ROMEN     = rom;
    bus.RAMEN     = ram;
    bus.DUARTEN   = duart;
    bus.EXT_DTACK = ext;
  endtask

  task automatic idle();
    drive(1, 1, 1, 1, 1);
    tick();
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1, 1, 1, 1, 1);
    tick();
    tick();
    checks++;
    if (bus.DTACK_OUT !== 1'b1) begin
      errors++;
      $display("FAIL reset_dtack: DTACK_OUT=%b expected 1", bus.DTACK_OUT);
    end
    checks++;
    if (bus.BERR !== 1'b1) begin
      errors++;
      $display("FAIL reset_berr: BERR=%b expected 1", bus.BERR);
    end
    RST = 1'b0;
    idle();
  endtask

  task automatic test_rom_access();
    logic exp;
    idle();
    drive(0, 0, 1, 1, 1);
    for (int e = 0; e < 6; e++) begin
      tick();
      exp = (e >= 3) ? 1'b0 : 1'b1;
      checks++;
      if (bus.DTACK_OUT !== exp) begin
        errors++;
        $display("FAIL rom_dtack edge %0d: DTACK_OUT=%b expected %b", e, bus.DTACK_OUT, exp);
      end
    end
    drive(1, 1, 1, 1, 1);
    tick();
    checks++;
    if (bus.DTACK_OUT !== 1'b1) begin
      errors++;
      $display("FAIL rom_release: DTACK_OUT=%b expected 1", bus.DTACK_OUT);
    end
    idle();
  endtask

  task automatic test_ram_access();
    logic exp;
    idle();
    drive(0, 1, 0, 1, 1);
    for (int e = 0; e < 4; e++) begin
      tick();
      exp = (e >= 1) ? 1'b0 : 1'b1;
      checks++;
      if (bus.DTACK_OUT !== exp) begin
        errors++;
        $display("FAIL ram_dtack edge %0d: DTACK_OUT=%b expected %b", e, bus.DTACK_OUT, exp);
      end
    end
    drive(1, 1, 1, 1, 1);
    tick();
    checks++;
    if (bus.DTACK_OUT !== 1'b1) begin
      errors++;
      $display("FAIL ram_release: DTACK_OUT=%b expected 1", bus.DTACK_OUT);
    end
    idle();
  endtask

  task automatic test_priority();
    logic exp;
    idle();
    drive(0, 0, 0, 1, 1);
    for (int e = 0; e < 5; e++) begin
      tick();
      exp = (e >= 3) ? 1'b0 : 1'b1;
      checks++;
      if (bus.DTACK_OUT !== exp) begin
        errors++;
        $display("FAIL prio_rom_ram edge %0d: DTACK_OUT=%b expected %b", e, bus.DTACK_OUT, exp);
      end
    end
    idle();
    drive(0, 0, 0, 0, 1);
    for (int e = 0; e < 6; e++) begin
      tick();
      exp = (e >= 4) ? 1'b0 : 1'b1;
      checks++;
      if (bus.DTACK_OUT !== exp) begin
        errors++;
        $display("FAIL prio_duart edge %0d: DTACK_OUT=%b expected %b", e, bus.DTACK_OUT, exp);
      end
    end
    idle();
  endtask

  task automatic test_abort();
    idle();
    drive(0, 1, 1, 0, 1);
    for (int e = 0; e < 8; e++) begin
      if (e == 2) drive(1, 1, 1, 1, 1);
      tick();
      checks++;
      if (bus.DTACK_OUT !== 1'b1) begin
        errors++;
        $display("FAIL abort_dtack edge %0d: DTACK_OUT=%b expected 1", e, bus.DTACK_OUT);
      end
    end
    drive(0, 1, 0, 1, 1);
    tick();
    checks++;
    if (bus.DTACK_OUT !== 1'b1) begin
      errors++;
      $display("FAIL abort_next_e0: DTACK_OUT=%b expected 1", bus.DTACK_OUT);
    end
    tick();
    checks++;
    if (bus.DTACK_OUT !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_e1: DTACK_OUT=%b expected 0", bus.DTACK_OUT);
    end
    idle();
  endtask

  task automatic test_enable_latch();
    logic exp;
    idle();
    drive(0, 0, 1, 1, 1);
    tick();
    drive(0, 1, 0, 1, 1);
    for (int e = 1; e < 6; e++) begin
      tick();
      exp = (e >= 3) ? 1'b0 : 1'b1;
      checks++;
      if (bus.DTACK_OUT !== exp) begin
        errors++;
        $display("FAIL latch_dtack edge %0d: DTACK_OUT=%b expected %b", e, bus.DTACK_OUT, exp);
      end
    end
    drive(0, 1, 1, 1, 1);
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if (bus.DTACK_OUT !== 1'b0) begin
        errors++;
        $display("FAIL latch_hold %0d: DTACK_OUT=%b expected 0", e, bus.DTACK_OUT);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    drive(0, 1, 0, 1, 1);
    tick();
    tick();
    checks++;
    if (bus.DTACK_OUT !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: DTACK_OUT=%b expected 0", bus.DTACK_OUT);
    end
    drive(1, 1, 0, 1, 1);
    tick();
    checks++;
    if (bus.DTACK_OUT !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release: DTACK_OUT=%b expected 1", bus.DTACK_OUT);
    end
    drive(0, 1, 0, 1, 1);
    for (int e = 0; e < 4; e++) begin
      tick();
      checks++;
      if (bus.DTACK_OUT !== 1'b1) begin
        errors++;
        $display("FAIL b2b_unarmed %0d: DTACK_OUT=%b expected 1", e, bus.DTACK_OUT);
      end
    end
    drive(1, 1, 0, 1, 1);
    tick();
    drive(0, 1, 0, 1, 1);
    tick();
    checks++;
    if (bus.DTACK_OUT !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_e0: DTACK_OUT=%b expected 1", bus.DTACK_OUT);
    end
    tick();
    checks++;
    if (bus.DTACK_OUT !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_e1: DTACK_OUT=%b expected 0", bus.DTACK_OUT);
    end
    idle();
  endtask

  task automatic test_no_enable();
    idle();
    drive(0, 1, 1, 1, 1);
    for (int e = 0; e < 5; e++) begin
      tick();
      checks++;
      if (bus.DTACK_OUT !== 1'b1) begin
        errors++;
        $display("FAIL no_enable %0d: DTACK_OUT=%b expected 1", e, bus.DTACK_OUT);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic exp;
    idle();
    drive(0, 0, 1, 1, 1);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (bus.DTACK_OUT !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_dtack: DTACK_OUT=%b expected 1", bus.DTACK_OUT);
    end
    for (int e = 0; e < 6; e++) begin
      tick();
      checks++;
      if (bus.DTACK_OUT !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_stuck %0d: DTACK_OUT=%b expected 1", e, bus.DTACK_OUT);
      end
    end
    drive(1, 0, 1, 1, 1);
    tick();
    drive(0, 0, 1, 1, 1);
    for (int e = 0; e < 4; e++) begin
      tick();
      exp = (e >= 3) ? 1'b0 : 1'b1;
      checks++;
      if (bus.DTACK_OUT !== exp) begin
        errors++;
        $display("FAIL rstmid_retry edge %0d: DTACK_OUT=%b expected %b", e, bus.DTACK_OUT, exp);
      end
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (bus.DTACK_OUT !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ack: DTACK_OUT=%b expected 1", bus.DTACK_OUT);
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if (bus.DTACK_OUT !== 1'b1) begin
        errors++;
        $display("FAIL rst_in_ack_hold %0d: DTACK_OUT=%b expected 1", e, bus.DTACK_OUT);
      end
    end
    idle();
  endtask

`ifdef MACK_BERR_TIMEOUT_EN
  task automatic test_timeout();
    logic exp;
    idle();
    drive(0, 1, 1, 1, 1);
    for (int e = 0; e < 70; e++) begin
      tick();
      exp = (e >= 64) ? 1'b0 : 1'b1;
      checks++;
      if (bus.BERR !== exp) begin
        errors++;
        $display("FAIL timeout_berr edge %0d: BERR=%b expected %b", e, bus.BERR, exp);
      end
    end
    drive(1, 1, 1, 1, 1);
    tick();
    checks++;
    if (bus.BERR !== 1'b1) begin
      errors++;
      $display("FAIL timeout_release: BERR=%b expected 1", bus.BERR);
    end
    idle();
    drive(0, 1, 1, 1, 1);
    for (int e = 0; e < 100; e++) begin
      if (e == 10) bus.EXT_DTACK = 1'b0;
      tick();
      checks++;
      if (bus.BERR !== 1'b1) begin
        errors++;
        $display("FAIL ext_dtack_berr edge %0d: BERR=%b expected 1", e, bus.BERR);
      end
    end
    idle();
  endtask
`else
  task automatic test_berr_disabled();
    idle();
    drive(0, 1, 1, 1, 1);
    for (int e = 0; e < 300; e++) begin
      tick();
      checks++;
      if (bus.BERR !== 1'b1) begin
        errors++;
        $display("FAIL berr_const edge %0d: BERR=%b expected 1", e, bus.BERR);
      end
    end
    idle();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    RST    = 1'b1;
    drive(1, 1, 1, 1, 1);
    test_reset();
    test_rom_access();
    test_ram_access();
    test_priority();
    test_abort();
    test_enable_latch();
    test_back_to_back();
    test_no_enable();
    test_reset_mid();
`ifdef MACK_BERR_TIMEOUT_EN
    test_timeout();
`else
    test_berr_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mack_dtack_gen.md
MACK_DTACK_GEN -- requirements
Module: mack_dtack_gen

Interface
REQ-001 Parameter ROM_WAIT, 2, wait states inserted before DTACK for ROM accesses (0-15).
REQ-002 Parameter RAM_WAIT, 0, wait states for RAM accesses (0-15).
REQ-003 Parameter DUART_WAIT, 3, wait states for DUART accesses (0-15).
REQ-004 Parameter TIMEOUT, 64, CLK cycles of unacknowledged AS before bus error (1-255).
REQ-005 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 AS  input  1  CPU address strobe, active-low, synchronous to CLK.
REQ-008 ROMEN, RAMEN, DUARTEN  input  1 each  chip enables from the address decoder, active-low.
REQ-009 EXT_DTACK  input  1  externally generated DTACK (MFP, IACK cycles), active-low; only halts the timeout.
REQ-010 DTACK_OUT  output  1  registered DTACK to the decoder's DTACK_IN, active-low.
REQ-011 BERR  output  1  registered bus error to CPU, active-low.

Function
REQ-012 States: IDLE, WAIT, ACK, FAULT; 2-bit state register.
REQ-013 Select priority when several enables are low: DUARTEN > ROMEN > RAMEN.
REQ-014 IDLE: AS low and an enable low at edge N -> load 4-bit counter with the selected wait count; go WAIT if count > 0, otherwise ACK.
REQ-015 WAIT: counter decrements each edge; at the edge where the counter equals 1 -> ACK.
REQ-016 DTACK_OUT low exactly from edge N+W+1 (W = selected wait count) for as long as state is ACK.
REQ-017 ACK: hold until AS sampled high -> IDLE, DTACK_OUT high at that same edge.
REQ-018 AS sampled high in WAIT (aborted cycle) -> IDLE; DTACK_OUT never asserted for that cycle.
REQ-019 Enable change during WAIT or ACK is ignored; the selection is latched at edge N.
REQ-020 Back-to-back cycles: AS must be sampled high at least one edge in IDLE before a new selection is accepted.
REQ-021 AS low with no enable in IDLE: remain in IDLE; DTACK_OUT stays high.

Reset
REQ-022 RST high at any edge -> state IDLE, DTACK_OUT=1, BERR=1, wait counter=0, timeout counter=0; this overrides any bus activity, including mid-cycle.
REQ-023 After RST deasserts, a cycle already in progress (AS low) is not acknowledged until AS returns high and falls again.

Configuration
REQ-024 Macro MACK_BERR_TIMEOUT_EN defined: an 8-bit timeout counter increments each edge while AS is low, DTACK_OUT is high and EXT_DTACK is high; the counter clears whenever AS is high or EXT_DTACK is low.
REQ-025 With the macro defined, the counter reaching TIMEOUT -> FAULT, BERR low from that edge; FAULT -> IDLE and BERR high at the first edge with AS high.
REQ-026 With the macro defined, a timeout during WAIT (TIMEOUT <= W) -> FAULT takes precedence over ACK at the same edge.
REQ-027 Macro undefined: no timeout counter or FAULT state is synthesised; BERR is constant 1.

Verification
REQ-028 ROM access, ROM_WAIT=2: AS and ROMEN low at edge 0 -> DTACK_OUT low at edge 3; AS high at edge 6 -> DTACK_OUT high at edge 6.
REQ-029 RAM access, RAM_WAIT=0: AS and RAMEN low at edge 0 -> DTACK_OUT low at edge 1; with ROMEN also low, the ROM wait count of 2 applies -> DTACK_OUT low at edge 3.
REQ-030 Aborted DUART cycle: AS and DUARTEN low at edge 0, AS high at edge 2 -> state IDLE, DTACK_OUT never low.
REQ-031 Timeout with macro defined and TIMEOUT=64: AS low with no enable and EXT_DTACK high -> BERR low at edge 64, BERR high at the first edge with AS high; the same stimulus with EXT_DTACK low at edge 10 -> BERR stays high.
REQ-032 Reset mid-cycle: RST high at edge 2 of a ROM_WAIT=2 access -> DTACK_OUT stays high and state is IDLE; no DTACK occurs until AS cycles high then low again.
REQ-033 Macro undefined: AS held low for 300 cycles with no enable -> BERR constant 1.
